// File: rtl/mata_reader_pkg.sv
// Shared dilithium definitions: ring/matrix dimensions, reader FSM states and
// the matA word-offset helper used by both the sampler and the reader.
package mata_reader_pkg;

  localparam int Q           = 8380417;
  localparam int N           = 256;
  localparam int K           = 8;
  localparam int L           = 7;
  localparam int COEFF_WIDTH = 24;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    FIN
  } rd_state_e;

  // Row-major layout: polynomial (kk,ll) occupies ncoef consecutive words.
  function automatic int matA_offset(input int kk, input int ll, input int nn,
                                     input int cols, input int ncoef);
    return kk * cols * ncoef + ll * ncoef + nn;
  endfunction

endpackage

// File: rtl/mata_reader_if.sv
// Control, BRAM read port and coefficient stream of the matA reader.
interface mata_reader_if #(
  parameter int ADDR_WIDTH  = 14,
  parameter int COEFF_WIDTH = 24
);

  logic                   start;
  logic [3:0]             k;
  logic [3:0]             l;
  logic                   busy;
  logic                   done;
  logic                   err;
  logic                   re_matA;
  logic [ADDR_WIDTH-1:0]  addr_matA;
  logic [COEFF_WIDTH-1:0] dout_matA;
  logic [COEFF_WIDTH-1:0] coeff_out;
  logic [7:0]             coeff_idx;
  logic                   coeff_valid;
  logic                   coeff_ready;
  logic                   coeff_last;

  modport master (
    input  start, k, l, dout_matA, coeff_ready,
    output busy, done, err, re_matA, addr_matA,
           coeff_out, coeff_idx, coeff_valid, coeff_last
  );

  modport slave (
    output start, k, l, dout_matA, coeff_ready,
    input  busy, done, err, re_matA, addr_matA,
           coeff_out, coeff_idx, coeff_valid, coeff_last
  );

endinterface

// File: rtl/mata_reader_coeff_skid_fifo.sv
// Two-entry FIFO holding returned coefficients; head is always presented on dout.
module coeff_skid_fifo
  import mata_reader_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             valid,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && (count != 2'd0);
  // When full, a push is only legal if the head leaves in the same cycle.
  assign do_push = push && ((count != 2'd2) || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) mem[i] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) rd_ptr <= ~rd_ptr;
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign dout  = mem[rd_ptr];
  assign valid = (count != 2'd0);

endmodule

// File: rtl/mata_reader.sv
// Streams one N-coefficient polynomial (k,l) of matrix A out of an external
// BRAM, with at most two coefficients read-but-not-delivered at any time.
module mata_reader
  import mata_reader_pkg::*;
#(
  parameter int K           = mata_reader_pkg::K,
  parameter int L           = mata_reader_pkg::L,
  parameter int N           = mata_reader_pkg::N,
  parameter int COEFF_WIDTH = mata_reader_pkg::COEFF_WIDTH,
  parameter int ADDR_WIDTH  = $clog2(K * L * N)
) (
  input logic           clk,
  input logic           rst_n,
  mata_reader_if.master bus
);

  localparam int CW = $clog2(N) + 1;
  localparam int FW = COEFF_WIDTH + 8;

  rd_state_e             state;
  logic [CW-1:0]         rd_cnt;
  logic [ADDR_WIDTH-1:0] base_q;
  logic                  pend_q;
  logic [7:0]            pend_idx_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  err_q;

  logic [1:0]            fifo_count;
  logic                  fifo_valid;
  logic [FW-1:0]         fifo_head;
  logic                  pop;
  logic                  last_head;
  logic [2:0]            occ;
  logic                  issue;
  logic                  sel_ok;

  assign sel_ok    = (32'(bus.k) < K) && (32'(bus.l) < L);
  assign pop       = fifo_valid && bus.coeff_ready;
  assign last_head = fifo_valid && (fifo_head[FW-1 -: 8] == 8'(N - 1));

  // Occupancy seen by the next cycle: buffered entries net of this cycle's
  // pop, plus the response currently on dout_matA. Using the post-pop count
  // keeps the stream at one beat per cycle while never exceeding two entries,
  // which is why re_matA has to be combinational on coeff_ready.
  assign occ   = {1'b0, fifo_count} + {2'b0, pend_q} - {2'b0, pop};
  assign issue = (state == READ) && (occ < 3'd2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      rd_cnt     <= '0;
      base_q     <= '0;
      pend_q     <= 1'b0;
      pend_idx_q <= 8'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      pend_q <= issue;
      if (issue) pend_idx_q <= 8'(rd_cnt);
      case (state)
        IDLE: begin
          if (bus.start && sel_ok) begin
            base_q <= ADDR_WIDTH'(matA_offset(int'(bus.k), int'(bus.l), 0, L, N));
            rd_cnt <= '0;
            err_q  <= 1'b0;
            busy_q <= 1'b1;
            state  <= READ;
          end else if (bus.start) begin
            err_q  <= 1'b1;
            busy_q <= 1'b1;
            done_q <= 1'b1;
            state  <= FIN;
          end
        end
        READ: begin
          if (issue) begin
            rd_cnt <= rd_cnt + CW'(1);
            if (rd_cnt == CW'(N - 1)) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (pop && last_head) begin
            done_q <= 1'b1;
            state  <= FIN;
          end
        end
        FIN: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Response stage: data returned for last cycle's read enters the FIFO
  coeff_skid_fifo #(
    .WIDTH (FW)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (pend_q),
    .din   ({pend_idx_q, bus.dout_matA}),
    .pop   (pop),
    .dout  (fifo_head),
    .valid (fifo_valid),
    .count (fifo_count)
  );

  // Output stage: stream straight from the FIFO head
  assign bus.busy        = busy_q || ((state == IDLE) && bus.start);
  assign bus.done        = done_q;
  assign bus.err         = err_q;
  assign bus.re_matA     = issue;
  assign bus.addr_matA   = base_q + ADDR_WIDTH'(rd_cnt);
  assign bus.coeff_out   = fifo_head[COEFF_WIDTH-1:0];
  assign bus.coeff_idx   = fifo_head[FW-1 -: 8];
  assign bus.coeff_valid = fifo_valid;
  assign bus.coeff_last  = last_head;

endmodule

// File: tb/tb_mata_reader.sv
// Randomized bench for mata_reader: BRAM model, stream scoreboard and
// per-transfer checks against the expected polynomial contents.
module tb_mata_reader;

  localparam int KR   = 8;
  localparam int LC   = 7;
  localparam int NC   = 256;
  localparam int CWID = 24;
  localparam int AW   = 14;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mata_reader_if #(.ADDR_WIDTH(AW), .COEFF_WIDTH(CWID)) bus ();

  mata_reader #(
    .K(KR), .L(LC), .N(NC), .COEFF_WIDTH(CWID), .ADDR_WIDTH(AW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [CWID-1:0] bram [KR*LC*NC];
  always @(posedge clk) if (bus.re_matA) bus.dout_matA <= bram[bus.addr_matA];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int unsigned ready_pct = 100;
  bit mon_en = 1'b0;
  int cur_k, cur_l, reads, beats, done_cnt, busy_cnt, done_err;
  int first_addr, last_addr, first_valid_cyc, last_beat_cyc, done_cyc, accept_cyc;
  bit held_v;
  logic [CWID-1:0] held_out;
  logic [7:0]      held_idx;
  logic            held_last;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Scoreboard: every read address and every accepted beat is checked
  // against the (k,l) polynomial's expected contents.
  always @(negedge clk) begin
    if (rst_n && mon_en) begin
      if (bus.busy) busy_cnt++;
      if (bus.re_matA) begin
        check_eq("addr", 32'(bus.addr_matA), 32'(cur_k*LC*NC + cur_l*NC + reads));
        if (reads == 0) first_addr = int'(bus.addr_matA);
        last_addr = int'(bus.addr_matA);
        reads++;
      end
      if (bus.coeff_valid) begin
        if (held_v) begin
          check_eq("stall_out",  32'(bus.coeff_out),  32'(held_out));
          check_eq("stall_idx",  32'(bus.coeff_idx),  32'(held_idx));
          check_eq("stall_last", 32'(bus.coeff_last), 32'(held_last));
        end
        if (bus.coeff_ready) begin
          if (beats == 0) first_valid_cyc = cyc;
          check_eq("data", 32'(bus.coeff_out), 32'(beats + 1000*(cur_k*LC + cur_l)));
          check_eq("idx",  32'(bus.coeff_idx), 32'(beats));
          check_eq("last", 32'(bus.coeff_last), 32'(beats == NC-1));
          beats++;
          last_beat_cyc = cyc;
          held_v = 1'b0;
        end else begin
          held_v    = 1'b1;
          held_out  = bus.coeff_out;
          held_idx  = bus.coeff_idx;
          held_last = bus.coeff_last;
        end
      end
      check_eq("outstanding_le_2", 32'(reads - beats <= 2), 32'd1);
      if (bus.done) begin
        done_cnt++;
        done_cyc = cyc;
        done_err = int'(bus.err);
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      bus.coeff_ready = ($urandom_range(99) < ready_pct);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_start(input int kk, input int ll);
    @(posedge clk);
    #1;
    reads = 0; beats = 0; done_cnt = 0; busy_cnt = 0; held_v = 1'b0;
    cur_k = kk; cur_l = ll; done_err = -1;
    bus.start = 1'b1;
    bus.k     = 4'(kk);
    bus.l     = 4'(ll);
    @(posedge clk);
    #1;
    bus.start  = 1'b0;
    accept_cyc = cyc;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int t = 0;
    while (done_cnt == 0 && t < budget) begin
      @(posedge clk);
      t++;
    end
    check_eq({tag, "_done_seen"}, 32'(done_cnt > 0), 32'd1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic wait_beats(input string tag, input int nb, input int budget);
    int t = 0;
    while (beats < nb && t < budget) begin
      @(posedge clk);
      t++;
    end
    check_eq({tag, "_beats_reached"}, 32'(beats >= nb), 32'd1);
  endtask

  task automatic check_xfer(input string tag);
    check_eq({tag, "_beats"},     32'(beats), 32'(NC));
    check_eq({tag, "_reads"},     32'(reads), 32'(NC));
    check_eq({tag, "_done_once"}, 32'(done_cnt), 32'd1);
    check_eq({tag, "_err"},       32'(done_err), 32'd0);
    check_eq({tag, "_done_lag"},  32'(done_cyc - last_beat_cyc), 32'd1);
    check_eq({tag, "_busy_after"}, 32'(bus.busy), 32'd0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "_busy"},  32'(bus.busy),        32'd0);
    check_eq({tag, "_done"},  32'(bus.done),        32'd0);
    check_eq({tag, "_err"},   32'(bus.err),         32'd0);
    check_eq({tag, "_re"},    32'(bus.re_matA),     32'd0);
    check_eq({tag, "_addr"},  32'(bus.addr_matA),   32'd0);
    check_eq({tag, "_out"},   32'(bus.coeff_out),   32'd0);
    check_eq({tag, "_idx"},   32'(bus.coeff_idx),   32'd0);
    check_eq({tag, "_valid"}, 32'(bus.coeff_valid), 32'd0);
    check_eq({tag, "_last"},  32'(bus.coeff_last),  32'd0);
  endtask

  task automatic bad_start(input string tag, input int kk, input int ll);
    do_start(kk, ll);
    wait_done(tag, 20);
    check_eq({tag, "_no_reads"}, 32'(reads), 32'd0);
    check_eq({tag, "_done_once"}, 32'(done_cnt), 32'd1);
    check_eq({tag, "_err_with_done"}, 32'(done_err), 32'd1);
    check_eq({tag, "_err_held"}, 32'(bus.err), 32'd1);
  endtask

  initial begin
    int kk, ll;
    bus.start = 1'b0;
    bus.k = 4'd0;
    bus.l = 4'd0;
    bus.coeff_ready = 1'b1;
    for (int a = 0; a < KR; a++)
      for (int b = 0; b < LC; b++)
        for (int n = 0; n < NC; n++)
          bram[a*LC*NC + b*NC + n] = CWID'(n + 1000*(a*LC + b));

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // Full-rate transfer with latency and throughput checks
    ready_pct = 100;
    do_start(2, 3);
    wait_done("k2l3", 2000);
    check_xfer("k2l3");
    check_eq("k2l3_latency", 32'(first_valid_cyc - accept_cyc), 32'd2);
    check_eq("k2l3_rate", 32'(last_beat_cyc - first_valid_cyc), 32'(NC - 1));

    ready_pct = 30;
    do_start(0, 0);
    wait_done("k0l0_bp", 5000);
    check_xfer("k0l0_bp");

    bad_start("k8l0", 8, 0);
    check_eq("k8l0_busy_cycles", 32'(busy_cnt), 32'd2);

    ready_pct = 100;
    do_start(7, 6);
    wait_done("k7l6", 2000);
    check_xfer("k7l6");
    check_eq("k7l6_first_addr", 32'(first_addr), 32'd14080);
    check_eq("k7l6_last_addr",  32'(last_addr),  32'd14335);

    // Reset mid-stream, then restart from index 0
    do_start(1, 2);
    wait_beats("rst_mid", 101, 1000);
    #2;
    rst_n = 1'b0;
    #1;
    check_outputs_zero("rst_mid");
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check_eq("rst_mid_no_done", 32'(done_cnt), 32'd0);
    check_eq("rst_mid_idle", 32'(bus.busy), 32'd0);
    do_start(1, 2);
    wait_done("restart", 2000);
    check_xfer("restart");

    // Start pulsed mid-transfer must be ignored
    ready_pct = 60;
    do_start(3, 4);
    wait_beats("start_busy", 50, 1000);
    @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.k = 4'd5;
    bus.l = 4'd1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_done("start_busy", 3000);
    check_xfer("start_busy");

    for (int t = 0; t < 3; t++) begin
      kk = int'($urandom_range(KR - 1));
      ll = int'($urandom_range(LC - 1));
      ready_pct = $urandom_range(100, 40);
      do_start(kk, ll);
      wait_done("rand", 3000);
      check_xfer("rand");
    end

    bad_start("rand_bad_k", int'($urandom_range(15, KR)), int'($urandom_range(15)));
    bad_start("rand_bad_l", int'($urandom_range(KR - 1)), int'($urandom_range(15, LC)));

    ready_pct = 100;
    do_start(4, 5);
    wait_done("err_clear", 2000);
    check_xfer("err_clear");
    check_eq("err_clear_level", 32'(bus.err), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
